// File: rtl/module_sequential_divider.sv
// Iterative restoring divider: one quotient bit per clock, MSB first, using a
// DIV_WIDTH+1-bit trial subtraction. Start/done handshake, one operation at a time.
// Optional feature macro: SIGNED_DIV_EN (two's-complement operands, truncating quotient,
// remainder carries the dividend's sign). Undefined -> unsigned only.
module module_sequential_divider #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DIV_WIDTH-1:0] dividend_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DIV_WIDTH-1:0] quotient_o,
  output logic [DIV_WIDTH-1:0] remainder_o,
  output logic                 div_by_zero_o
);

  localparam int unsigned CntW = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               r_state;
  logic [DIV_WIDTH-1:0] r_dvd;      // dividend shift register (magnitude when signed)
  logic [DIV_WIDTH-1:0] r_dvs;      // divisor (magnitude when signed)
  logic [DIV_WIDTH-1:0] r_rem;      // partial remainder, always < divisor
  logic [DIV_WIDTH-1:0] r_quo;      // quotient bits shifted in so far
  logic [CntW-1:0]      r_cnt;
  logic                 r_zero;     // latched divisor == 0
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;
  logic [DIV_WIDTH-1:0] r_quotient;
  logic [DIV_WIDTH-1:0] r_remainder;

  logic [DIV_WIDTH:0]   w_shift;
  logic [DIV_WIDTH:0]   w_trial;
  logic                 w_qbit;
  logic [DIV_WIDTH-1:0] w_rem_next;
  logic [DIV_WIDTH-1:0] w_quo_next;
  logic [DIV_WIDTH-1:0] w_q_final;
  logic [DIV_WIDTH-1:0] w_r_final;
  logic [DIV_WIDTH-1:0] w_dvd_abs;
  logic [DIV_WIDTH-1:0] w_dvs_abs;

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
  assign w_shift    = {r_rem, r_dvd[DIV_WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_trial[DIV_WIDTH];
  assign w_rem_next = w_qbit ? w_trial[DIV_WIDTH-1:0] : w_shift[DIV_WIDTH-1:0];
  assign w_quo_next = {r_quo[DIV_WIDTH-2:0], w_qbit};

`ifdef SIGNED_DIV_EN
  logic r_neg_q;
  logic r_neg_r;

  // MIN stays MIN as an unsigned magnitude, so MIN / -1 naturally yields quotient MIN.
  assign w_dvd_abs = dividend_i[DIV_WIDTH-1] ? -dividend_i : dividend_i;
  assign w_dvs_abs = divisor_i[DIV_WIDTH-1] ? -divisor_i : divisor_i;
  assign w_q_final = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_final = r_neg_r ? -w_rem_next : w_rem_next;

  // Result signs captured on the accepting edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == StIdle && start_i) begin
      r_neg_q <= dividend_i[DIV_WIDTH-1] ^ divisor_i[DIV_WIDTH-1];
      r_neg_r <= dividend_i[DIV_WIDTH-1];
    end
  end
`else
  assign w_dvd_abs = dividend_i;
  assign w_dvs_abs = divisor_i;
  assign w_q_final = w_quo_next;
  assign w_r_final = w_rem_next;
`endif

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_zero      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start_i) begin
            // Zero-divisor path keeps the raw dividend: it is returned as the remainder.
            r_dvd  <= (divisor_i == '0) ? dividend_i : w_dvd_abs;
            r_dvs  <= w_dvs_abs;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= CntW'(DIV_WIDTH);
            r_zero <= (divisor_i == '0);
            r_dbz  <= 1'b0;
            r_busy <= 1'b1;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          if (r_zero) begin
            // Divide by zero spends a single cycle here so done_o follows E0+1.
            r_quotient  <= '1;
            r_remainder <= r_dvd;
            r_dbz       <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_dvd <= {r_dvd[DIV_WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) begin
              r_quotient  <= w_q_final;
              r_remainder <= w_r_final;
              r_done      <= 1'b1;
              r_state     <= StDone;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign quotient_o    = r_quotient;
  assign remainder_o   = r_remainder;
  assign div_by_zero_o = r_dbz;

endmodule

// File: tb/tb_module_sequential_divider.sv
// Self-checking bench for module_sequential_divider (DIV_WIDTH = 8).
// Expected results come from plain integer arithmetic; signed cases run when SIGNED_DIV_EN is set.
module tb_module_sequential_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy_o;
  logic       done_o;
  logic [7:0] quotient_o;
  logic [7:0] remainder_o;
  logic       div_by_zero_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  module_sequential_divider #(.DIV_WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_by_zero_o(div_by_zero_o)
  );

  // Reference: arithmetic division with the documented zero/overflow rules.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r, output logic z);
`ifdef SIGNED_DIV_EN
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == 8'd0) begin
      q = 8'hFF; r = a; z = 1'b1;
    end else if (sa == -128 && sb == -1) begin
      q = 8'h80; r = 8'h00; z = 1'b0;
    end else begin
      q = 8'(sa / sb); r = 8'(sa % sb); z = 1'b0;
    end
`else
    if (b == 8'd0) begin
      q = 8'hFF; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
`endif
  endfunction

  // Issue one op, return cycles from E0 to done (-1 on timeout) and busy cycle count.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                        output int nbusy, output logic [7:0] q, output logic [7:0] r,
                        output logic z);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    lat = 0; nbusy = 0;
    while (done_o !== 1'b1 && lat < 40) begin
      if (busy_o === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (done_o === 1'b1) begin
      if (busy_o === 1'b1) nbusy++;
      q = quotient_o; r = remainder_o; z = div_by_zero_o;
    end else begin
      lat = -1; q = 'x; r = 'x; z = 1'bx;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_o, done_o, div_by_zero_o, quotient_o, remainder_o} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got b=%b d=%b z=%b q=%h r=%h, want all 0",
               busy_o, done_o, div_by_zero_o, quotient_o, remainder_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'd100, 8'd255, 8'd5, 8'd200};
    logic [7:0] tb [4] = '{8'd7, 8'd1, 8'd9, 8'd200};
    logic [7:0] tq [4] = '{8'd14, 8'd255, 8'd0, 8'd1};
    logic [7:0] tr [4] = '{8'd2, 8'd0, 8'd5, 8'd0};
    int lat, nb;
    logic [7:0] q, r;
    logic z;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], lat, nb, q, r, z);
      n_cmp++;
      if (lat !== 8) begin
        n_err++; $display("FAIL dir_latency[%0d]: got %0d, want 8", i, lat);
      end
      n_cmp++;
      if (nb !== 9) begin
        n_err++; $display("FAIL dir_busy_cycles[%0d]: got %0d, want 9", i, nb);
      end
      n_cmp++;
      if (q !== tq[i] || r !== tr[i] || z !== 1'b0) begin
        n_err++;
        $display("FAIL dir_result[%0d]: got q=%h r=%h z=%b, want q=%h r=%h z=0",
                 i, q, r, z, tq[i], tr[i]);
      end
      @(negedge clk);
      n_cmp++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || quotient_o !== tq[i]) begin
        n_err++;
        $display("FAIL dir_after_done[%0d]: got d=%b b=%b q=%h, want d=0 b=0 q=%h",
                 i, done_o, busy_o, quotient_o, tq[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, nb, k;
    logic [7:0] q, r;
    logic z;
    run_op(8'h5A, 8'h00, lat, nb, q, r, z);
    n_cmp++;
    if (lat !== 1) begin
      n_err++; $display("FAIL dbz_latency: got %0d, want 1", lat);
    end
    n_cmp++;
    if (q !== 8'hFF || r !== 8'h5A || z !== 1'b1) begin
      n_err++; $display("FAIL dbz_result: got q=%h r=%h z=%b, want q=ff r=5a z=1", q, r, z);
    end
    // Next op: flag clears on accept, quotient held until the new result loads.
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (div_by_zero_o !== 1'b0 || quotient_o !== 8'hFF) begin
      n_err++;
      $display("FAIL dbz_clear_hold: got z=%b q=%h, want z=0 q=ff", div_by_zero_o, quotient_o);
    end
    k = 0;
    while (done_o !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    n_cmp++;
    if (done_o !== 1'b1 || quotient_o !== 8'd14 || remainder_o !== 8'd2) begin
      n_err++;
      $display("FAIL dbz_next_op: got d=%b q=%h r=%h, want d=1 q=0e r=02",
               done_o, quotient_o, remainder_o);
    end
  endtask

  task automatic test_start_held();
    int acc, dn, first, last, k;
    logic prev;
    acc = 0; dn = 0; first = -1; last = -1;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    prev = busy_o;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy_o === 1'b1 && prev === 1'b0) begin
        acc++;
        if (first < 0) first = i;
        last = i;
      end
      if (done_o === 1'b1) dn++;
      prev = busy_o;
    end
    start = 1'b0;
    n_cmp++;
    if (acc !== 4 || dn !== 4) begin
      n_err++; $display("FAIL held_counts: got acc=%0d done=%0d, want 4 and 4", acc, dn);
    end
    n_cmp++;
    if (last - first !== 30) begin
      n_err++; $display("FAIL held_period: got span %0d, want 30", last - first);
    end
    n_cmp++;
    if (quotient_o !== 8'd14 || remainder_o !== 8'd2) begin
      n_err++; $display("FAIL held_result: got q=%h r=%h, want q=0e r=02", quotient_o, remainder_o);
    end
    k = 0;
    while (busy_o !== 1'b0 && k < 20) begin @(negedge clk); k++; end
  endtask

  task automatic test_ignore_mid();
    int k;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done_o !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    n_cmp++;
    if (done_o !== 1'b1 || quotient_o !== 8'd14 || remainder_o !== 8'd2) begin
      n_err++;
      $display("FAIL mid_start_result: got d=%b q=%h r=%h, want d=1 q=0e r=02",
               done_o, quotient_o, remainder_o);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL mid_start_not_queued: got busy=%b, want 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nb, dn;
    logic [7:0] q, r;
    logic z;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy_o, done_o, div_by_zero_o, quotient_o, remainder_o} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got b=%b d=%b z=%b q=%h r=%h, want all 0",
               busy_o, done_o, div_by_zero_o, quotient_o, remainder_o);
    end
    dn = 0;
    repeat (12) begin @(negedge clk); if (done_o === 1'b1) dn++; end
    n_cmp++;
    if (dn !== 0) begin
      n_err++; $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", dn);
    end
    run_op(8'd9, 8'd3, lat, nb, q, r, z);
    n_cmp++;
    if (lat !== 8 || q !== 8'd3 || r !== 8'd0) begin
      n_err++; $display("FAIL reset_mid_fresh: got lat=%0d q=%h r=%h, want 8 03 00", lat, q, r);
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    int lat, nb;
    logic [7:0] q, r;
    logic z;
    run_op(8'h9C, 8'd7, lat, nb, q, r, z);
    n_cmp++;
    if (lat !== 8 || q !== 8'hF2 || r !== 8'hFE || z !== 1'b0) begin
      n_err++;
      $display("FAIL signed_neg100_7: got lat=%0d q=%h r=%h z=%b, want 8 f2 fe 0", lat, q, r, z);
    end
    run_op(8'h80, 8'hFF, lat, nb, q, r, z);
    n_cmp++;
    if (lat !== 8 || q !== 8'h80 || r !== 8'h00 || z !== 1'b0) begin
      n_err++;
      $display("FAIL signed_overflow: got lat=%0d q=%h r=%h z=%b, want 8 80 00 0", lat, q, r, z);
    end
  endtask
`endif

  task automatic test_random();
    int lat, nb;
    logic [7:0] a, b, q, r, eq, er;
    logic z, ez;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      model(a, b, eq, er, ez);
      run_op(a, b, lat, nb, q, r, z);
      n_cmp++;
      if (lat !== ((b == 8'd0) ? 1 : 8)) begin
        n_err++; $display("FAIL rand_latency %h/%h: got %0d, want %0d",
                          a, b, lat, (b == 8'd0) ? 1 : 8);
      end
      n_cmp++;
      if (q !== eq || r !== er || z !== ez) begin
        n_err++;
        $display("FAIL rand_result %h/%h: got q=%h r=%h z=%b, want q=%h r=%h z=%b",
                 a, b, q, r, z, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_start_held();
    test_ignore_mid();
    test_reset_mid();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
